alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_picker.sv | 15 +
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the bit positions of the captured flag vector.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_COMP = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b110;
    localparam logic [2:0] ALU_BAD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // rsp_flags = {carry, sign, overflow, zero}
    localparam int FLAG_W     = 4;
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 0;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr.
module alu_rr_picker (
    input  logic valid0,
    input  logic valid1,
    input  logic rr,
    output logic grant_any,
    output logic grant_id
);

    always_comb begin
        grant_any = valid0 | valid1;
        grant_id  = (valid0 & valid1) ? rr : valid1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; one operation
// in flight, response held until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int ALUCSIZE = 3
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALUCSIZE-1:0] req0_op,
    input  logic [SIZE-1:0]     req0_a,
    input  logic [SIZE-1:0]     req0_b,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALUCSIZE-1:0] req1_op,
    input  logic [SIZE-1:0]     req1_a,
    input  logic [SIZE-1:0]     req1_b,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [SIZE-1:0]     rsp_result,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic                rsp_err,

    output logic [ALUCSIZE-1:0] alu_control,
    output logic [SIZE-1:0]     alu_operand0,
    output logic [SIZE-1:0]     alu_operand1,
    input  logic [SIZE-1:0]     alu_result,
    input  logic                alu_carry,
    input  logic                alu_sign,
    input  logic                alu_overflow,
    input  logic                alu_zero
);

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic                id_q, id_d;
    logic [ALUCSIZE-1:0] op_q, op_d;
    logic [SIZE-1:0]     a_q, a_d;
    logic [SIZE-1:0]     b_q, b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [SIZE-1:0]     rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;

    logic                grant_any;
    logic                grant_id;
    logic                grant_now;
    logic [FLAG_W-1:0]   alu_flags;

    alu_rr_picker u_picker (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .rr        (rr_q),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    always_comb begin
        alu_flags             = '0;
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_SIGN]  = alu_sign;
        alu_flags[FLAG_OVF]   = alu_overflow;
        alu_flags[FLAG_ZERO]  = alu_zero;
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign grant_now  = (state_q == ST_IDLE) && grant_any && rst_n;
    assign req0_ready = grant_now && !grant_id;
    assign req1_ready = grant_now && grant_id;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    state_d = ST_EXEC;
                    rr_d    = ~grant_id;
                    id_d    = grant_id;
                    op_d    = grant_id ? req1_op : req0_op;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (op_q == ALUCSIZE'(ALU_BAD)) begin
                    rsp_result_d = '0;
                    rsp_flags_d  = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The ALU inputs come straight from the issue registers, so they only move on a grant.
    assign alu_control  = op_q;
    assign alu_operand0 = a_q;
    assign alu_operand1 = b_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, transaction-level reference
// model, directed scenarios followed by a randomized phase.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [2:0]  alu_control;
    logic [31:0] alu_operand0, alu_operand1, alu_result;
    logic        alu_carry, alu_sign, alu_overflow, alu_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.SIZE(32), .ALUCSIZE(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_control(alu_control), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    // {carry, sign, overflow, zero, result}; opcode 111 yields junk the DUT must ignore
    function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = '0; w = '0;
        case (op)
            ALU_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                            v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_COMP: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            default:  return {4'hF, 32'hDEAD_BEEF};
        endcase
        return {c, r[31], v, (r == 32'd0), r};
    endfunction

    always_comb {alu_carry, alu_sign, alu_overflow, alu_zero, alu_result} =
        alu_ref(alu_control, alu_operand0, alu_operand1);

    int errors = 0;
    int checks = 0;

    // requester side: a pending op is held until the arbiter accepts it
    bit          pend[2];
    bit          auto_refill[2];
    bit          rand_mode = 1'b0;
    logic [2:0]  p_op[2];
    logic [31:0] p_a[2], p_b[2];

    // reference model
    bit          in_flight = 1'b0;
    int          cyc = 0, resp_cyc = 0;
    bit          rr_m = 1'b0;
    logic [2:0]  last_op = '0;
    logic [31:0] last_a = '0, last_b = '0;
    logic        e_id, e_err;
    logic [31:0] e_res;
    logic [3:0]  e_flg;

    // observed traffic
    int          glog[$];
    logic [37:0] rlog[$];
    int          n_rsp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_op(input int i);
        pend[i] = 1'b1;
        p_op[i] = 3'($urandom_range(0, 7));
        p_a[i]  = $urandom;
        p_b[i]  = $urandom;
    endtask

    task automatic set_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
    endtask

    // one clock cycle; entered and left at a falling edge
    task automatic step();
        int g;
        bit ev;
        if (rand_mode) rsp_ready = ($urandom_range(0, 9) < 7);
        req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
        #1;
        g = -1;
        if (!in_flight && (pend[0] || pend[1]))
            g = (pend[0] && pend[1]) ? int'(rr_m) : (pend[0] ? 0 : 1);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        ev = in_flight && (cyc >= resp_cyc);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_result", rsp_result, e_res);
            chk("rsp_flags", rsp_flags, e_flg);
            chk("rsp_err", rsp_err, e_err);
        end
        chk("alu_control", alu_control, last_op);
        chk("alu_operands", {alu_operand0, alu_operand1}, {last_a, last_b});
        if (req0_ready) glog.push_back(0);
        if (req1_ready) glog.push_back(1);
        if (rsp_valid && rsp_ready) begin
            rlog.push_back({rsp_err, rsp_id, rsp_flags, rsp_result});
            $display("rsp  t=%0t id=%0d result=%h flags=%b err=%0d", $time, rsp_id, rsp_result, rsp_flags, rsp_err);
            n_rsp++;
        end
        if (ev && rsp_ready) in_flight = 1'b0;
        if (g >= 0) begin
            if (p_op[g] == ALU_BAD) begin
                e_res = '0; e_flg = '0; e_err = 1'b1;
            end else begin
                {e_flg, e_res} = alu_ref(p_op[g], p_a[g], p_b[g]);
                e_err = 1'b0;
            end
            e_id = (g == 1);
            last_op = p_op[g]; last_a = p_a[g]; last_b = p_b[g];
            in_flight = 1'b1;
            resp_cyc = cyc + 2;
            rr_m = (g == 0);
            pend[g] = 1'b0;
            if (auto_refill[g]) new_op(g);
        end
        if (rand_mode)
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 9) < 4) new_op(i);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until(input int target, input int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            step();
            k++;
        end
        chk("rsp_within_budget", n_rsp >= target, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 4'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_alu_control", alu_control, 3'd0);
        chk("rst_alu_operands", {alu_operand0, alu_operand1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ready", {req0_ready, req1_ready}, 2'b00);
        rst_n = 1'b1;
        in_flight = 1'b0; rr_m = 1'b0;
        last_op = '0; last_a = '0; last_b = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        glog.delete(); rlog.delete();
    endtask

    initial begin
        int exp_alt[6];
        exp_alt = '{0, 1, 0, 1, 0, 1};
        pend[0] = 0; pend[1] = 0; auto_refill[0] = 0; auto_refill[1] = 0;
        p_op[0] = '0; p_op[1] = '0; p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0;
        @(negedge clk);
        do_reset();

        // overflowing add from requester 0
        rsp_ready = 1'b1;
        set_op(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        run_until(n_rsp + 1, 10);
        if (rlog.size() >= 1) chk("add_rsp", rlog[0], {1'b0, 1'b0, 4'b0110, 32'h8000_0000});

        // tie after reset: requester 0 first, then requester 1, then lone requester 1
        do_reset();
        set_op(0, ALU_XOR, 32'h5, 32'h5);
        set_op(1, ALU_AND, 32'hF0, 32'h0F);
        run_until(n_rsp + 2, 12);
        set_op(1, ALU_ADD, 32'd3, 32'd4);
        run_until(n_rsp + 1, 8);
        chk("tie_grant_count", glog.size(), 3);
        if (glog.size() >= 3) begin
            chk("tie_grant0", glog[0], 0);
            chk("tie_grant1", glog[1], 1);
            chk("lone_grant1", glog[2], 1);
        end
        if (rlog.size() >= 2) begin
            chk("tie_rsp0", rlog[0], {1'b0, 1'b0, 4'b0001, 32'h0});
            chk("tie_rsp1", rlog[1], {1'b0, 1'b1, 4'b0001, 32'h0});
        end

        // both requesters continuously busy: grants must alternate
        glog.delete();
        auto_refill[0] = 1; auto_refill[1] = 1;
        new_op(0); new_op(1);
        run_until(n_rsp + 6, 30);
        auto_refill[0] = 0; auto_refill[1] = 0;
        run_idle(12);
        for (int i = 0; i < 6; i++)
            if (glog.size() > i) chk("alternate_grant", glog[i], exp_alt[i]);

        // back-pressure on the response while requester 1 waits
        rlog.delete();
        rsp_ready = 1'b0;
        set_op(0, ALU_SRA, 32'h8000_0000, 32'd4);
        run_idle(2);
        set_op(1, ALU_XOR, 32'h1234_5678, 32'hFFFF_0000);
        run_idle(5);
        rsp_ready = 1'b1;
        run_idle(8);
        if (rlog.size() >= 1) chk("sra_rsp", rlog[0], {1'b0, 1'b0, 4'b0100, 32'hF800_0000});

        // unsupported opcode from requester 1
        rlog.delete();
        set_op(1, ALU_BAD, $urandom, $urandom);
        run_until(n_rsp + 1, 8);
        if (rlog.size() >= 1) chk("bad_rsp", rlog[0], {1'b1, 1'b1, 4'b0000, 32'h0});

        // reset while the operation is executing
        set_op(0, ALU_ADD, 32'd10, 32'd20);
        run_idle(1);
        do_reset();
        run_idle(5);
        set_op(0, ALU_ADD, 32'd100, 32'd23);
        run_until(n_rsp + 1, 8);
        if (rlog.size() >= 1) chk("post_reset_rsp", rlog[0], {1'b0, 1'b0, 4'b0000, 32'd123});

        // randomized traffic with random back-pressure
        rand_mode = 1'b1;
        run_idle(400);
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        run_idle(20);
        chk("final_idle", rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
